// File: rtl/spi_flash_pkg.sv
// Shared constants and FSM encoding for the SPI flash line reader.
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;

  localparam int CMD_BITS   = 8;
  localparam int ADDR_BITS  = 24;
  localparam int DUMMY_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DUMMY = 3'd3,
    ST_DATA  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // True in the states where CS is asserted and SCK runs.
  function automatic logic spi_active(input state_e s);
    return (s == ST_CMD) || (s == ST_ADDR) || (s == ST_DUMMY) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/spi_sck_divider.sv
// SPI clock generator: SCK level plus one-cycle rise/fall strobes, CLK_DIV clk per half period.
module spi_sck_divider #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       phase_q, phase_d;
  logic       tick;

  assign tick = en && (cnt_q == LAST);

  // Disabled means parked low with a cleared count, so every transfer starts on a fresh low half.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!en) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (tick) begin
      cnt_d   = '0;
      phase_d = !phase_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign sck  = phase_q;
  assign rise = tick && !phase_q;
  assign fall = tick && phase_q;

endmodule

// File: rtl/spi_flash_line_reader.sv
// Read-only CPU window onto SPI flash with a single prefetch line buffer.
// Misses stall the CPU while one aligned line is streamed in over SPI mode 0.
module spi_flash_line_reader
  import spi_flash_pkg::*;
#(
  parameter int          ADDR_W     = 16,
  parameter logic [23:0] FLASH_BASE = 24'h000000,
  parameter int          CLK_DIV    = 1,
  parameter int          FAST_READ  = 0,
  parameter int          LINE_BYTES = 4
) (
  input  logic              clk,
  input  logic              i_RESET_N,
  input  logic              spi_ce,
  input  logic [ADDR_W-1:0] i_ADDRESS_BUS,
  input  logic              i_RW,
  input  logic              i_FLUSH,
  input  logic              i_SPI_MISO,
  output logic              o_SPI_CLK,
  output logic              o_SPI_MOSI,
  output logic              o_SPI_CS,
  output logic [7:0]        o_DATA,
  output logic              o_MemoryReady,
  output logic              o_BUSY
);

  localparam int          OFF_W     = $clog2(LINE_BYTES);
  localparam int          IDX_W     = (OFF_W == 0) ? 1 : OFF_W;
  localparam int          DATA_BITS = 8 * LINE_BYTES;
  localparam logic [23:0] OFF_MASK  = 24'(LINE_BYTES - 1);
  localparam logic [7:0]  CMD_BYTE  = (FAST_READ != 0) ? CMD_FAST_READ : CMD_READ;

  state_e      state_q, state_d;
  logic [7:0]  bit_cnt_q, bit_cnt_d;
  logic [39:0] tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic [23:0] base_q, base_d;
  logic        valid_q, valid_d;
  logic        flush_pend_q, flush_pend_d;
  logic [7:0]  line_q [LINE_BYTES];
  logic [7:0]  line_d [LINE_BYTES];

  logic [23:0]      flash_addr;
  logic [23:0]      line_addr;
  logic [IDX_W-1:0] off;
  logic [IDX_W-1:0] byte_idx;
  logic [7:0]       last_bit;
  logic             req, hit;
  logic             sck_en, sck_rise, sck_fall;

  assign req        = spi_ce && i_RW;
  assign flash_addr = FLASH_BASE + 24'(i_ADDRESS_BUS);
  assign line_addr  = flash_addr & ~OFF_MASK;
  assign off        = IDX_W'(flash_addr & OFF_MASK);
  assign byte_idx   = IDX_W'(bit_cnt_q >> 3);
  assign hit        = req && valid_q && (state_q == ST_IDLE) && (line_addr == base_q);

  assign sck_en = spi_active(state_q);

  spi_sck_divider #(.CLK_DIV(CLK_DIV)) u_sck (
    .clk  (clk),
    .rst_n(i_RESET_N),
    .en   (sck_en),
    .sck  (o_SPI_CLK),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  always_comb begin
    last_bit = 8'd0;
    case (state_q)
      ST_CMD:   last_bit = 8'(CMD_BITS - 1);
      ST_ADDR:  last_bit = 8'(ADDR_BITS - 1);
      ST_DUMMY: last_bit = 8'(DUMMY_BITS - 1);
      ST_DATA:  last_bit = 8'(DATA_BITS - 1);
      default:  last_bit = 8'd0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    base_d       = base_q;
    valid_d      = valid_q;
    flush_pend_d = flush_pend_q;
    line_d       = line_q;
    case (state_q)
      ST_IDLE: begin
        if (i_FLUSH) valid_d = 1'b0;
        if (req && !hit) begin
          state_d      = ST_CMD;
          base_d       = line_addr;
          valid_d      = 1'b0;
          flush_pend_d = 1'b0;
          bit_cnt_d    = '0;
          tx_d         = {CMD_BYTE, line_addr, 8'h00};
        end
      end
      ST_DONE: begin
        // A flush seen at any point during the fill keeps the new line invalid.
        valid_d      = !flush_pend_q && !i_FLUSH;
        flush_pend_d = 1'b0;
        state_d      = ST_IDLE;
      end
      default: begin
        if (i_FLUSH) flush_pend_d = 1'b1;
        if (sck_rise && (state_q == ST_DATA)) begin
          rx_d = {rx_q[6:0], i_SPI_MISO};
          if (bit_cnt_q[2:0] == 3'd7) line_d[byte_idx] = {rx_q[6:0], i_SPI_MISO};
        end
        if (sck_fall) begin
          tx_d = {tx_q[38:0], 1'b0};
          if (bit_cnt_q == last_bit) begin
            bit_cnt_d = '0;
            case (state_q)
              ST_CMD:   state_d = ST_ADDR;
              ST_ADDR:  state_d = (FAST_READ != 0) ? ST_DUMMY : ST_DATA;
              ST_DUMMY: state_d = ST_DATA;
              default:  state_d = ST_DONE;
            endcase
          end else begin
            bit_cnt_d = bit_cnt_q + 8'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      tx_q         <= '0;
      rx_q         <= '0;
      base_q       <= '0;
      valid_q      <= 1'b0;
      flush_pend_q <= 1'b0;
      for (int i = 0; i < LINE_BYTES; i++) line_q[i] <= 8'h00;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      base_q       <= base_d;
      valid_q      <= valid_d;
      flush_pend_q <= flush_pend_d;
      line_q       <= line_d;
    end
  end

  // MOSI is only meaningful during the header; it idles low otherwise.
  assign o_SPI_MOSI    = tx_q[39] && ((state_q == ST_CMD) || (state_q == ST_ADDR) || (state_q == ST_DUMMY));
  assign o_SPI_CS      = !sck_en;
  assign o_BUSY        = (state_q != ST_IDLE);
  assign o_MemoryReady = (state_q == ST_IDLE) && (!req || hit);
  assign o_DATA        = hit ? line_q[off] : 8'h00;

endmodule

// File: tb/tb_spi_flash_line_reader.sv
// Scoreboarded bench: a default-configured reader and a FAST_READ/CLK_DIV=3 reader
// share one stimulus bus and one behavioural SPI flash model.
module tb_spi_flash_line_reader;
  timeunit 1ns;
  timeprecision 1ps;

  localparam int CLK_NS = 10;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce    = 1'b0;
  logic        rw    = 1'b0;
  logic        flush = 1'b0;
  logic        sel   = 1'b0;
  logic        rd_req = 1'b0;
  logic [15:0] addr  = 16'h0000;
  logic        f_miso = 1'b0;

  logic       ce_a, ce_b, flush_a, flush_b;
  logic       sck_a, mosi_a, cs_a, rdy_a, busy_a;
  logic       sck_b, mosi_b, cs_b, rdy_b, busy_b;
  logic [7:0] data_a, data_b;
  logic       f_sck, f_mosi, f_cs, f_ready, f_busy;
  logic [7:0] f_data;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  assign ce_a    = ce && !sel;
  assign ce_b    = ce && sel;
  assign flush_a = flush && !sel;
  assign flush_b = flush && sel;
  assign f_sck   = sel ? sck_b  : sck_a;
  assign f_mosi  = sel ? mosi_b : mosi_a;
  assign f_cs    = sel ? cs_b   : cs_a;
  assign f_ready = sel ? rdy_b  : rdy_a;
  assign f_busy  = sel ? busy_b : busy_a;
  assign f_data  = sel ? data_b : data_a;

  always #(CLK_NS / 2) clk = ~clk;

  spi_flash_line_reader #(.ADDR_W(16)) u_dut_a (
    .clk(clk), .i_RESET_N(rst_n), .spi_ce(ce_a), .i_ADDRESS_BUS(addr), .i_RW(rw),
    .i_FLUSH(flush_a), .i_SPI_MISO(f_miso), .o_SPI_CLK(sck_a), .o_SPI_MOSI(mosi_a),
    .o_SPI_CS(cs_a), .o_DATA(data_a), .o_MemoryReady(rdy_a), .o_BUSY(busy_a)
  );

  spi_flash_line_reader #(.ADDR_W(16), .FLASH_BASE(24'hFFFFF0), .CLK_DIV(3),
                          .FAST_READ(1), .LINE_BYTES(4)) u_dut_b (
    .clk(clk), .i_RESET_N(rst_n), .spi_ce(ce_b), .i_ADDRESS_BUS(addr), .i_RW(rw),
    .i_FLUSH(flush_b), .i_SPI_MISO(f_miso), .o_SPI_CLK(sck_b), .o_SPI_MOSI(mosi_b),
    .o_SPI_CS(cs_b), .o_DATA(data_b), .o_MemoryReady(rdy_b), .o_BUSY(busy_b)
  );

  // Flash contents: a simple address hash.
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
  endfunction

  int          bitn      = 0;
  int          last_bits = 0;
  int          cs_falls  = 0;
  logic [39:0] sh        = '0;
  logic [7:0]  cap_cmd   = 8'h00;
  logic [7:0]  cap_dummy = 8'hFF;
  logic [23:0] cap_addr  = 24'h0;
  longint      last_rise = 0;
  longint      per_min   = 0;
  longint      per_max   = 0;

  always @(posedge f_sck or negedge f_cs) begin
    if (f_sck !== 1'b1) begin
      cs_falls++;
      bitn    = 0;
      sh      = '0;
      per_min = 1000000;
      per_max = 0;
    end else if (f_cs === 1'b0) begin
      if (bitn > 0) begin
        if ($time - last_rise < per_min) per_min = $time - last_rise;
        if ($time - last_rise > per_max) per_max = $time - last_rise;
      end
      last_rise = $time;
      sh = {sh[38:0], f_mosi};
      bitn++;
      if (bitn == 8)  cap_cmd   = sh[7:0];
      if (bitn == 32) cap_addr  = sh[23:0];
      if (bitn == 40) cap_dummy = sh[7:0];
    end
  end

  always @(posedge f_cs) last_bits = bitn;

  always @(negedge f_sck) begin
    if (f_cs === 1'b0) begin
      int hdr;
      int k;
      logic [7:0] b;
      hdr = (cap_cmd == 8'h0B) ? 40 : 32;
      if (bitn >= hdr) begin
        k = bitn - hdr;
        b = flash_byte(cap_addr + 24'(k / 8));
        f_miso = b[7 - (k % 8)];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: one pop per served read.
  always @(negedge clk) begin
    if (rd_req && f_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rdata: got 0x%0h with no expected entry", f_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("rdata", 64'(f_data), 64'(e));
      end
    end
  end

  task automatic do_read(input logic [15:0] a, input logic [7:0] exp_byte, input int exp_wait,
                         input logic [23:0] exp_line, input logic with_flush);
    int waits;
    int cs0;
    logic done;
    @(posedge clk); #1;
    cs0 = cs_falls;
    ce = 1'b1; rw = 1'b1; addr = a; flush = with_flush; rd_req = 1'b1;
    exp_q.push_back(exp_byte);
    waits = 0;
    done  = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (f_ready) done = 1'b1;
      else waits++;
    end
    @(posedge clk); #1;
    ce = 1'b0; rw = 1'b0; flush = 1'b0; rd_req = 1'b0;
    check("ready_seen", 64'(done), 64'd1);
    check("wait_cycles", 64'(waits), 64'(exp_wait));
    check("cs_starts", 64'(cs_falls - cs0), (exp_wait > 0) ? 64'd1 : 64'd0);
    if (exp_wait > 0) begin
      check("cmd", 64'(cap_cmd), sel ? 64'h0B : 64'h03);
      check("line_addr", 64'(cap_addr), 64'(exp_line));
      check("sck_rises", 64'(last_bits), sel ? 64'd72 : 64'd64);
      check("sck_period_min", 64'(per_min), sel ? 64'(6 * CLK_NS) : 64'(2 * CLK_NS));
      check("sck_period_max", 64'(per_max), sel ? 64'(6 * CLK_NS) : 64'(2 * CLK_NS));
      if (sel) check("dummy", 64'(cap_dummy), 64'h00);
    end
    $display("[TB] read dut=%0d addr=0x%04h waits=%0d", sel, a, waits);
  endtask

  // Request held for one edge only, so the fill runs with the CPU gone.
  task automatic start_and_drop(input logic [15:0] a, input int hold, input logic do_flush);
    logic done;
    @(posedge clk); #1;
    ce = 1'b1; rw = 1'b1; addr = a;
    @(posedge clk); #1;
    ce = 1'b0; rw = 1'b0;
    @(negedge clk);
    check("busy_after_drop", 64'(f_busy), 64'd1);
    repeat (hold) @(posedge clk);
    #1 flush = do_flush;
    @(posedge clk); #1 flush = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (!f_busy) done = 1'b1;
    end
    check("fill_finished", 64'(done), 64'd1);
    $display("[TB] dropped fill addr=0x%04h flush=%0d", a, do_flush);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cs0;
    logic done;

    repeat (3) @(negedge clk);
    check("rst_cs", 64'(f_cs), 64'd1);
    check("rst_sck", 64'(f_sck), 64'd0);
    check("rst_mosi", 64'(f_mosi), 64'd0);
    check("rst_data", 64'(f_data), 64'h00);
    check("rst_busy", 64'(f_busy), 64'd0);
    check("rst_ready", 64'(f_ready), 64'd1);
    $display("[TB] reset checks done");
    @(posedge clk); #1 rst_n = 1'b1;

    do_read(16'h1234, 8'h83, 130, 24'h001234, 1'b0);
    do_read(16'h1235, 8'h82, 0, 24'h0, 1'b0);
    do_read(16'h1236, 8'h81, 0, 24'h0, 1'b0);
    do_read(16'h1237, 8'h80, 0, 24'h0, 1'b0);
    do_read(16'h1238, 8'h8F, 130, 24'h001238, 1'b0);
    do_read(16'h1239, 8'h8E, 0, 24'h0, 1'b1);
    do_read(16'h1239, 8'h8E, 130, 24'h001238, 1'b0);

    @(posedge clk); #1;
    cs0 = cs_falls;
    ce = 1'b1; rw = 1'b0; addr = 16'h2000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("write_ready", 64'(f_ready), 64'd1);
    end
    check("write_busy", 64'(f_busy), 64'd0);
    check("write_no_cs", 64'(cs_falls - cs0), 64'd0);
    @(posedge clk); #1 ce = 1'b0;
    $display("[TB] write ignored addr=0x2000");

    start_and_drop(16'h5002, 30, 1'b0);
    do_read(16'h5002, 8'hF7, 0, 24'h0, 1'b0);
    start_and_drop(16'h3001, 40, 1'b1);
    do_read(16'h3001, 8'h94, 130, 24'h003000, 1'b0);

    @(posedge clk); #1;
    ce = 1'b1; rw = 1'b1; addr = 16'h4003;
    done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (bitn == 29) done = 1'b1;
    end
    check("reached_addr_bit20", 64'(done), 64'd1);
    #2 rst_n = 1'b0;
    ce = 1'b0; rw = 1'b0;
    #1;
    check("midfill_rst_cs", 64'(f_cs), 64'd1);
    check("midfill_rst_sck", 64'(f_sck), 64'd0);
    check("midfill_rst_busy", 64'(f_busy), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    $display("[TB] reset during address phase");
    do_read(16'h4003, 8'hE6, 130, 24'h004000, 1'b0);

    @(posedge clk); #1 sel = 1'b1;
    do_read(16'h0012, 8'hA7, 434, 24'h000000, 1'b0);
    do_read(16'h0011, 8'hA4, 0, 24'h0, 1'b0);
    do_read(16'h000F, 8'h5A, 434, 24'hFFFFFC, 1'b0);

    repeat (4) @(posedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_flash_line_reader.md
SPI_FLASH_LINE_READER -- requirements
Module: spi_flash_line_reader

Interface
REQ-001 Parameter ADDR_W, default 16: CPU address bus width, 8..24.
REQ-002 Parameter FLASH_BASE, default 24'h000000: 24-bit flash offset added to the CPU address.
REQ-003 Parameter CLK_DIV, default 1: clk cycles per SPI clock half-period, 1..255.
REQ-004 Parameter FAST_READ, default 0: 0 selects command 0x03; 1 selects command 0x0B with one dummy byte.
REQ-005 Parameter LINE_BYTES, default 4: prefetch line size, power of two, 1..16.
REQ-006 clk  in  1  system clock; all state changes on the rising edge.
REQ-007 i_RESET_N  in  1  asynchronous active-low reset.
REQ-008 spi_ce  in  1  flash window select from the address decoder.
REQ-009 i_ADDRESS_BUS  in  ADDR_W  CPU byte address.
REQ-010 i_RW  in  1  1 = read; writes (0) are ignored.
REQ-011 i_FLUSH  in  1  single-cycle pulse that invalidates the line buffer.
REQ-012 i_SPI_MISO  in  1  flash serial data out.
REQ-013 o_SPI_CLK  out  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-014 o_SPI_MOSI  out  1  flash serial data in; driven low when idle, never high-Z.
REQ-015 o_SPI_CS  out  1  flash chip select, active low.
REQ-016 o_DATA  out  8  read data to the CPU.
REQ-017 o_MemoryReady  out  1  0 = CPU wait state.
REQ-018 o_BUSY  out  1  1 while a line fill is in progress.

Function
REQ-019 A request is spi_ce=1 and i_RW=1; flash address = FLASH_BASE + zero-extended i_ADDRESS_BUS, truncated to 24 bits.
REQ-020 A hit is a request with a valid line whose tag (address bits above log2(LINE_BYTES)) matches and the FSM in IDLE.
- On a hit, o_DATA is the buffered byte combinationally and o_MemoryReady stays 1: zero wait states.
REQ-021 o_MemoryReady = 0 combinationally while a request is not a hit, and in every cycle the FSM is not IDLE.
REQ-022 FSM states: IDLE, CMD, ADDR, DUMMY, DATA, DONE.
- IDLE->CMD on a non-hit request; the line-aligned address is latched and valid is cleared.
- CMD->ADDR after 8 bits.
- ADDR->DUMMY after 24 bits if FAST_READ=1, otherwise ADDR->DATA.
- DUMMY->DATA after 8 bits.
- DATA->DONE after 8*LINE_BYTES bits.
- DONE->IDLE after one cycle; valid is set there.
REQ-023 o_SPI_CS = 0 in CMD through DATA and 1 in IDLE and DONE; DONE gives a minimum CS-high time of 1 clk.
REQ-024 o_SPI_CLK toggles every CLK_DIV clk cycles in CMD..DATA; it starts low and ends low, with 2*CLK_DIV clk per bit.
REQ-025 MOSI is set up at least CLK_DIV clk before each SPI rising edge, MSB first: command, then 24-bit aligned address, then dummy 0x00.
REQ-026 MISO is sampled on each SPI rising edge during DATA, MSB first, with bytes stored in the buffer in ascending address order.
REQ-027 Fill latency is 1 + 2*CLK_DIV*(32 + 8*FAST_READ + 8*LINE_BYTES) + 1 clk from the request edge to o_MemoryReady=1, with the byte then served as a hit.
REQ-028 A request that drops during a fill does not abort it; the fill completes and the line becomes valid.
REQ-029 i_FLUSH in IDLE clears valid. i_FLUSH during a fill causes the completed line to stay invalid. i_FLUSH in the same cycle as a hit causes the hit to be served from the old data and valid to clear after that cycle.
REQ-030 The address wraps modulo 2^24; a line never crosses an aligned LINE_BYTES boundary.
REQ-031 o_BUSY = 1 in all states except IDLE.

Reset
REQ-032 i_RESET_N=0 asynchronously forces the following: state IDLE, o_SPI_CS=1, o_SPI_CLK=0, o_SPI_MOSI=0, o_DATA=8'h00, valid=0, counters 0.
- o_MemoryReady follows REQ-021; o_BUSY=0.
REQ-033 Reset mid-fill aborts the transfer immediately with CS high, and no partial line becomes valid.

Structure
REQ-034 Package spi_flash_pkg holds the commands (CMD_READ=8'h03, CMD_FAST_READ=8'h0B), the FSM state encoding, and the bit-count constants.
REQ-035 One sub-module, spi_sck_divider, generates SPI clock enable pulses (rise/fall strobes) from CLK_DIV.
- The FSM, shift registers and line buffer stay in the top module.

Verification
REQ-036 Defaults (CLK_DIV=1, FAST_READ=0, LINE_BYTES=4), read 0x1234 -> MOSI carries 0x03, 0x001234 aligned to 0x001234; ready low 130 clk; o_DATA equals the flash model byte.
REQ-037 After REQ-036, reads of 0x1235, 0x1236 and 0x1237 -> o_MemoryReady stays 1 and there is no CS activity; a read of 0x1238 -> new fill.
REQ-038 FAST_READ=1, CLK_DIV=3 -> command 0x0B, then 8 dummy clocks; SCK period is 6 clk; fill is 2+6*72 clk.
REQ-039 i_FLUSH pulsed mid-fill -> fill completes; a re-read of the same address triggers a second fill.
REQ-040 i_RESET_N low at bit 20 of ADDR -> CS=1 and SCK=0 in the same cycle; after release, a read of the same address performs a full fill.
REQ-041 i_RW=0 with spi_ce=1 -> no SPI activity, o_MemoryReady=1.
